// File: rtl/conv_out_collector.sv
// Collects 4-pixel groups from the convolution filter into a small group FIFO and
// serialises them into a single coordinate-tagged pixel stream. Optional: OUT_CHECKSUM_EN.
module conv_out_collector #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_pixel0,
    input  logic [DATA_W-1:0]        in_pixel1,
    input  logic [DATA_W-1:0]        in_pixel2,
    input  logic [DATA_W-1:0]        in_pixel3,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pixel,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [15:0]              checksum
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int GRP_W = 4 * DATA_W;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    logic [GRP_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [1:0]        lane_q, lane_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic [GRP_W-1:0]  head_grp, in_grp;
    logic [DATA_W-1:0] head_lane [4];
    logic              full, xfer, pop, push, last_pix, wr_en;
    logic [PTR_W-1:0]  wr_addr;

    assign in_grp   = {in_pixel3, in_pixel2, in_pixel1, in_pixel0};
    assign head_grp = mem_q[rd_ptr_q];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign head_lane[gi] = head_grp[gi*DATA_W +: DATA_W];
    end

    assign full      = (count_q == CNT_FULL);
    assign out_valid = (count_q != '0);
    // A transfer in a frame_start cycle is discarded, so it neither pops nor counts.
    assign xfer      = out_valid && out_ready && !frame_start;
    assign pop       = xfer && (lane_q == 2'd3);
    assign in_ready  = !full || pop;
    assign push      = in_valid && in_ready;
    assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);

    assign out_pixel  = head_lane[lane_q];
    assign out_col    = col_q;
    assign out_row    = row_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    assign wr_en   = frame_start ? in_valid : push;
    assign wr_addr = frame_start ? '0 : wr_ptr_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lane_d       = lane_q;
        col_d        = col_q;
        row_d        = row_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        if (frame_start) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = in_valid ? PTR_W'(1) : '0;
            count_d    = in_valid ? CNT_ONE : '0;
            lane_d     = 2'd0;
            col_d      = '0;
            row_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (xfer) begin
                lane_d       = lane_q + 2'd1;
                frame_done_d = last_pix;
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lane_q       <= 2'd0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lane_q       <= lane_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in_grp;
        end
    end

`ifdef OUT_CHECKSUM_EN
    logic [15:0] acc_q, acc_d, sum_q, sum_d, acc_plus;

    assign acc_plus = acc_q + 16'(out_pixel);

    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (frame_start) begin
            acc_d = '0;
            sum_d = '0;
        end else if (xfer) begin
            if (last_pix) begin
                sum_d = acc_plus;
                acc_d = '0;
            end else begin
                acc_d = acc_plus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/conv_out_collector.md
Name: conv_out_collector

Overview:
- Downstream stage of the convolution filter. Accepts four parallel filtered pixels per valid cycle (lanes 0..3), buffers them in a group FIFO, and serialises them into one pixel stream with a valid/ready handshake.
- Attaches row/column coordinates to every pixel and flags end-of-frame.
- Feeds the bitmap writer / result checker. The filter has no backpressure, so loss is flagged rather than prevented.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 256, image width in pixels; must be a multiple of 4.
- IMG_H, 256, image height in pixels.
- FIFO_DEPTH, 4, number of 4-pixel groups buffered; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  synchronous clear of FIFO, counters and flags; one-cycle pulse.
- in_valid  in  1  filter output valid (out_valid0 of filter).
- in_pixel0..in_pixel3  in  DATA_W each  filter lanes; lane 0 is the leftmost pixel of the group.
- in_ready  out  1  group FIFO can accept this cycle (status only; the filter ignores it).
- out_valid  out  1  out_pixel valid.
- out_ready  in  1  consumer accepts out_pixel.
- out_pixel  out  DATA_W  serialised pixel.
- out_col  out  $clog2(IMG_W)  column of out_pixel.
- out_row  out  $clog2(IMG_H)  row of out_pixel.
- frame_done  out  1  one-cycle pulse on acceptance of the last pixel of a frame.
- overflow  out  1  sticky: a group was dropped.
- checksum  out  16  frame checksum (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous) clears everything: FIFO empty, lane index 0, out_col=0, out_row=0, frame_done=0, overflow=0, checksum=0.
  - Consequently out_valid=0 and in_ready=1.
- Push:
  - in_ready = !full || (pop of lane 3 this cycle).
  - in_valid && in_ready writes {pixel3..pixel0} at the rising edge.
  - in_valid && !in_ready drops the group, sets overflow, and leaves FIFO contents unchanged.
- Latency: a group pushed into an empty FIFO at edge N gives out_valid=1 with lane 0 from edge N (registered FIFO head, combinational lane mux). First pixel is visible the cycle after in_valid.
- Pop/serialise:
  - out_valid = FIFO not empty. out_pixel = head group lane[lane_idx].
  - Transfer happens when out_valid && out_ready.
  - On each transfer, lane_idx increments 0→1→2→3. On a transfer at lane 3, the head group is popped and lane_idx returns to 0.
  - out_pixel, out_col and out_row stay stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full when the pop is at lane 3; the count is unchanged.
  - Pushing into an empty FIFO while nothing is popped: the new group becomes head on the next cycle.
- Coordinates:
  - out_col increments per transfer and wraps IMG_W-1→0, incrementing out_row.
  - Transfer at (IMG_H-1, IMG_W-1): frame_done=1 for exactly the next cycle, then out_row and out_col wrap to 0. Later groups start a new frame.
- frame_start:
  - Clears FIFO, lane_idx, counters, overflow and checksum at the edge.
  - If in_valid is high in the same cycle, that group is written into the freshly cleared FIFO (count becomes 1).
  - Any transfer in that cycle is discarded and does not advance counters.
- Reset mid-frame: all state is lost immediately; no partial-frame outputs after release.

Optional Feature:
- Macro OUT_CHECKSUM_EN.
- Defined:
  - A 16-bit running sum (mod 2^16) of every transferred out_pixel is kept.
  - checksum updates on the cycle frame_done rises and holds the final frame sum until the next frame_done, frame_start or reset.
  - The accumulator restarts at 0 after frame_done.
- Undefined: checksum is tied to 0; no accumulator logic is synthesised.

Test Plan:
- Single group: reset, then in_valid once with pixels 10,20,30,40, out_ready=1 → out_pixel 10,20,30,40 on 4 consecutive cycles starting one cycle after push; cols 0..3, row 0; out_valid then 0.
- Backpressure: push one group, hold out_ready=0 for 5 cycles → out_pixel=lane0 value and out_col=0 held stable, out_valid=1 throughout; release → remaining order unchanged.
- Overflow: FIFO_DEPTH=4, out_ready=0, in_valid for 5 cycles → in_ready=0 at the 5th, overflow=1 sticky; the 4 stored groups drain intact in order; frame_start clears overflow.
- Full with concurrent pop: FIFO full, out_ready=1, push exactly on the lane-3 transfer cycle → group accepted, overflow stays 0, count stays 4.
- Frame wrap: IMG_W=8, IMG_H=2, stream 4 groups with pixel value = index 0..15 → frame_done pulses once after pixel 15 at (row 1, col 7); next pixel at (0,0). With OUT_CHECKSUM_EN, checksum=120.
- Async reset mid-stream: assert rst_n=0 between edges with 2 groups queued → out_valid, frame_done and overflow go to 0 immediately; after release in_ready=1 and coordinates are (0,0).
